// File: rtl/ibex_wb_buffer_if.sv
// Handover, LSU-response and RF-write signals of the single-entry writeback stage.
// master = surrounding pipeline (EX/LSU/RF side), slave = the writeback buffer.
interface ibex_wb_buffer_if;
    logic        en_wb_i;
    logic [1:0]  instr_type_wb_i;
    logic [4:0]  rf_waddr_id_i;
    logic [31:0] rf_wdata_id_i;
    logic        rf_we_id_i;
    logic        ready_wb_o;
    logic        lsu_resp_valid_i;
    logic        lsu_resp_err_i;
    logic [31:0] rf_wdata_lsu_i;
    logic [4:0]  rf_waddr_wb_o;
    logic [31:0] rf_wdata_wb_o;
    logic        rf_we_wb_o;
    logic        instr_done_wb_o;
    logic        lsu_err_wb_o;
    logic        outstanding_mem_wb_o;

    modport master (
        output en_wb_i, instr_type_wb_i, rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i,
               lsu_resp_valid_i, lsu_resp_err_i, rf_wdata_lsu_i,
        input  ready_wb_o, rf_waddr_wb_o, rf_wdata_wb_o, rf_we_wb_o,
               instr_done_wb_o, lsu_err_wb_o, outstanding_mem_wb_o
    );

    modport slave (
        input  en_wb_i, instr_type_wb_i, rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i,
               lsu_resp_valid_i, lsu_resp_err_i, rf_wdata_lsu_i,
        output ready_wb_o, rf_waddr_wb_o, rf_wdata_wb_o, rf_we_wb_o,
               instr_done_wb_o, lsu_err_wb_o, outstanding_mem_wb_o
    );
endinterface

// File: rtl/ibex_wb_buffer.sv
// Single-entry writeback stage: holds one retiring instruction and drives the RF write port.
// IBEX_WB_LOAD_BYPASS_EN: retire loads/stores combinationally in the LSU response cycle.
module ibex_wb_buffer #(
    parameter bit ResetAll = 1'b0
) (
    input logic             clk_i,
    input logic             rst_ni,
    ibex_wb_buffer_if.slave wb
);

`ifdef IBEX_WB_LOAD_BYPASS_EN
    typedef enum logic [1:0] {EMPTY, RESULT, WAIT_RESP} wb_state_e;
`else
    typedef enum logic [1:0] {EMPTY, RESULT, WAIT_RESP, RESP_HELD} wb_state_e;
    logic err_q;
`endif

    wb_state_e   state_q;
    logic        load_q, we_q;
    logic [4:0]  waddr_q;
    logic [31:0] wdata_q;

    logic        is_mem, handover, done, err, we_raw, resp_capture, data_en;
    logic [31:0] wdata_out, wdata_d;

    assign is_mem   = (wb.instr_type_wb_i == 2'd1) | (wb.instr_type_wb_i == 2'd2);
    assign handover = wb.en_wb_i & wb.ready_wb_o;

    always_comb begin
        done      = 1'b0;
        err       = 1'b0;
        we_raw    = 1'b0;
        wdata_out = wdata_q;
        case (state_q)
            RESULT: begin
                done   = 1'b1;
                we_raw = we_q;
            end
            WAIT_RESP: begin
`ifdef IBEX_WB_LOAD_BYPASS_EN
                if (wb.lsu_resp_valid_i) begin
                    done      = 1'b1;
                    err       = wb.lsu_resp_err_i;
                    we_raw    = load_q & we_q & ~wb.lsu_resp_err_i;
                    wdata_out = wb.rf_wdata_lsu_i;
                end
`endif
            end
`ifndef IBEX_WB_LOAD_BYPASS_EN
            RESP_HELD: begin
                done   = 1'b1;
                err    = err_q;
                we_raw = load_q & we_q & ~err_q;
            end
`endif
            default: ;
        endcase
    end

    // Response data is registered only when the bypass is disabled.
`ifdef IBEX_WB_LOAD_BYPASS_EN
    assign resp_capture = 1'b0;
`else
    assign resp_capture = (state_q == WAIT_RESP) & wb.lsu_resp_valid_i;
`endif

    assign wb.ready_wb_o           = (state_q == EMPTY) | done;
    assign wb.instr_done_wb_o      = done;
    assign wb.lsu_err_wb_o         = err;
    assign wb.rf_we_wb_o           = we_raw & (|waddr_q);
    assign wb.rf_waddr_wb_o        = waddr_q;
    assign wb.rf_wdata_wb_o        = wdata_out;
    assign wb.outstanding_mem_wb_o = (state_q == WAIT_RESP);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            load_q  <= 1'b0;
            we_q    <= 1'b0;
`ifndef IBEX_WB_LOAD_BYPASS_EN
            err_q   <= 1'b0;
`endif
        end else begin
            if (handover) begin
                state_q <= is_mem ? WAIT_RESP : RESULT;
                load_q  <= (wb.instr_type_wb_i == 2'd1);
                we_q    <= wb.rf_we_id_i;
            end else if (done) begin
                state_q <= EMPTY;
            end
`ifndef IBEX_WB_LOAD_BYPASS_EN
            else if (resp_capture) begin
                state_q <= RESP_HELD;
                err_q   <= wb.lsu_resp_err_i;
            end
`endif
        end
    end

    // Data registers: reset only when ResetAll is set.
    assign data_en = handover | resp_capture;
    assign wdata_d = handover ? wb.rf_wdata_id_i : wb.rf_wdata_lsu_i;

    if (ResetAll) begin : g_data_rst
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                waddr_q <= 5'd0;
                wdata_q <= 32'd0;
            end else if (data_en) begin
                if (handover) waddr_q <= wb.rf_waddr_id_i;
                wdata_q <= wdata_d;
            end
        end
    end else begin : g_data_norst
        always_ff @(posedge clk_i) begin
            if (data_en) begin
                if (handover) waddr_q <= wb.rf_waddr_id_i;
                wdata_q <= wdata_d;
            end
        end
    end

endmodule

// File: doc/ibex_wb_buffer.md
# ibex_wb_buffer

Single-entry writeback stage between `ibex_ex_block` and the register file. It holds one retiring instruction handed over from EX: either an ALU/multdiv result or an outstanding load or store. It merges the LSU response into the held instruction and drives the register-file write port. It also back-pressures EX with `ready_wb_o` so that writes commit in program order.

## Interface
Parameters:
- `ResetAll`, default 0: when 1, the data registers (`wdata_q`, `waddr_q`) are also reset to 0. Otherwise only control state is reset.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `en_wb_i`  in  1  EX offers an instruction this cycle.
- `instr_type_wb_i`  in  2  0 = ALU/multdiv, 1 = load, 2 = store, 3 = reserved (treated as 0).
- `rf_waddr_id_i`  in  5  destination register.
- `rf_wdata_id_i`  in  32  EX result (`result_ex_o`).
- `rf_we_id_i`  in  1  instruction writes `rd`.
- `ready_wb_o`  out  1  WB can accept an instruction this cycle.
- `lsu_resp_valid_i`  in  1  LSU response strobe.
- `lsu_resp_err_i`  in  1  bus error with the response.
- `rf_wdata_lsu_i`  in  32  load data.
- `rf_waddr_wb_o`  out  5  RF write address.
- `rf_wdata_wb_o`  out  32  RF write data.
- `rf_we_wb_o`  out  1  RF write enable.
- `instr_done_wb_o`  out  1  held instruction retires this cycle (one-cycle pulse).
- `lsu_err_wb_o`  out  1  retiring load/store had a bus error (pulse).
- `outstanding_mem_wb_o`  out  1  held instruction is waiting for an LSU response.

## Operation
- Handover occurs when `en_wb_i && ready_wb_o`. On handover, the stage captures type, `waddr`, `wdata` and `we` into a single entry.
- `ready_wb_o = (state==EMPTY) | instr_done_wb_o`. This allows back-to-back handover in the cycle the held entry retires.
- States:
  - EMPTY
  - RESULT: a non-memory instruction is held.
  - WAIT_RESP: a load or store awaits its response.
  - RESP_HELD: only present without `IBEX_WB_LOAD_BYPASS_EN`.
- EMPTY → RESULT on handover of type 0/3. EMPTY → WAIT_RESP on handover of type 1/2.
- RESULT retires unconditionally in the cycle it is held:
  - `instr_done_wb_o=1`.
  - `rf_we_wb_o = we_q & (waddr_q!=0)`.
  - Next state is EMPTY, or the type-dependent state if a new handover happens in the same cycle.
- WAIT_RESP leaves on `lsu_resp_valid_i`, as described under Configuration.
- Stores never write the RF. A load writes only if `we_q`, `waddr_q!=0` and there is no error.
- On error, `lsu_err_wb_o=1` together with `instr_done_wb_o`, and `rf_we_wb_o=0`.
- `lsu_resp_valid_i` in any state other than WAIT_RESP is ignored and has no effect.
- `outstanding_mem_wb_o = (state==WAIT_RESP)`.
- Writes to x0 are never emitted.
- `rf_waddr_wb_o` always equals `waddr_q`.

## Timing
- Reset state:
  - state = EMPTY.
  - `ready_wb_o=1`.
  - `rf_we_wb_o`, `instr_done_wb_o`, `lsu_err_wb_o` and `outstanding_mem_wb_o` are 0.
  - `rf_waddr_wb_o` and `rf_wdata_wb_o` show the captured data registers. Their value is X unless `ResetAll`=1, in which case it is 0.
- Reset asserted mid-WAIT_RESP drops the entry without a write or done pulse. A late response after reset is ignored.
- ALU latency: handover in cycle N gives the RF write in cycle N+1.
- Load latency is measured from the response cycle R, and is set by the macro.
- `en_wb_i` while `ready_wb_o=0`: the instruction is not captured. EX must hold it.

## Configuration
- `IBEX_WB_LOAD_BYPASS_EN` defined:
  - In response cycle R, the stage retires combinationally: `rf_wdata_wb_o = rf_wdata_lsu_i`, with `rf_we_wb_o`, `instr_done_wb_o` and `ready_wb_o` high in R.
  - RESP_HELD does not exist.
- Not defined:
  - In R, the response data and error are registered and the state moves WAIT_RESP → RESP_HELD. `ready_wb_o` stays 0 in R.
  - RESP_HELD retires in R+1, with `rf_wdata_wb_o` coming from the register. This yields a fully registered RF write path.

## Test plan
- ALU handover: `rd`=5, data 0xDEADBEEF, handover in cycle 1 → `rf_we_wb_o=1`, `waddr`=5, `wdata`=0xDEADBEEF, `instr_done` pulse, all in cycle 2.
- Back-to-back ALU ops to x1, x2, x3 in cycles 1–3 → `ready_wb_o` stays 1, with writes to x1, x2, x3 in cycles 2–4.
- Load to x7 with the response 3 cycles after handover, data 0x12345678:
  - `outstanding_mem_wb_o=1` while waiting.
  - `ready_wb_o=0` while waiting.
  - Write of 0x12345678 in R with the macro, or in R+1 without it.
- Load to x7 with `lsu_resp_err_i=1` → `lsu_err_wb_o` and `instr_done` pulse, `rf_we_wb_o=0`. Also: a store with a clean response → done with no write. Also: an ALU op to x0 → done, `rf_we_wb_o=0`.
- Stray `lsu_resp_valid_i` while EMPTY → no output change.
- Reset pulse during WAIT_RESP, then a response → no write and no done; state EMPTY, `ready_wb_o=1`.
